// File: rtl/elastic_pipe_register.sv
// elastic_pipe_register: DEPTH cascaded 2-entry skid-buffer stages on a valid/ready
// stream. Every ready is decoded from registered stage state, so out_ready never
// reaches in_ready combinationally. Payload MSBs [DATAW-1 -: RESETW] are cleared by reset.
module elastic_pipe_register #(
    parameter int DATAW  = 8,
    parameter int RESETW = DATAW,
    parameter int DEPTH  = 1,
    // DEPTH==0 would give a zero-width count, so it is held at one bit there
    parameter int CNTW   = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_e;

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;

            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_data  = in_data;
            assign count     = '0;
            assign empty     = 1'b1;
            assign full      = 1'b1;
        end else begin : g_pipe
            localparam logic [DATAW-1:0] ALL_ONES  = '1;
            localparam logic [DATAW-1:0] KEEP_MASK = ALL_ONES >> RESETW;
            localparam logic [CNTW-1:0]  CNT_MAX   = CNTW'(2 * DEPTH);

            logic [DEPTH-1:0] stg_valid;
            logic [DEPTH-1:0] stg_ready;
            logic [DATAW-1:0] stg_data [DEPTH];
            logic [CNTW-1:0]  count_q, count_d;
            logic             push_in, pop_out;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                stage_state_e     state_q, state_d;
                logic [DATAW-1:0] main_q, main_d, skid_q, skid_d;
                logic [DATAW-1:0] up_data;
                logic             up_valid, dn_ready;
                logic             o_valid, i_ready, push, pop;

                if (k == 0) begin : g_first
                    assign up_valid = in_valid;
                    assign up_data  = in_data;
                end else begin : g_chain
                    assign up_valid = stg_valid[k-1];
                    assign up_data  = stg_data[k-1];
                end

                if (k == DEPTH - 1) begin : g_last
                    assign dn_ready = out_ready;
                end else begin : g_inner
                    assign dn_ready = stg_ready[k+1];
                end

                assign push = up_valid && i_ready;
                assign pop  = o_valid && dn_ready;

                // Stage occupancy state register
                always_ff @(posedge clk) begin
                    if (!reset) state_q <= ST_EMPTY;
                    else        state_q <= state_d;
                end

                // Payload registers: reset clears the MSB field, LSBs just hold
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        main_q <= main_q & KEEP_MASK;
                        skid_q <= skid_q & KEEP_MASK;
                    end else begin
                        main_q <= main_d;
                        skid_q <= skid_d;
                    end
                end

                // Next state and payload moves for one skid stage
                always_comb begin
                    state_d = state_q;
                    main_d  = main_q;
                    skid_d  = skid_q;
                    case (state_q)
                        ST_EMPTY: begin
                            if (push) begin
                                state_d = ST_ONE;
                                main_d  = up_data;
                            end
                        end
                        ST_ONE: begin
                            if (push && !pop) begin
                                state_d = ST_TWO;
                                skid_d  = up_data;
                            end else if (!push && pop) begin
                                state_d = ST_EMPTY;
                            end else if (push && pop) begin
                                main_d  = up_data;
                            end
                        end
                        ST_TWO: begin
                            if (pop) begin
                                state_d = ST_ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end

                // Handshake outputs decoded from registered state only
                always_comb begin
                    o_valid = (state_q != ST_EMPTY);
                    i_ready = (state_q != ST_TWO);
                end

                assign stg_valid[k] = o_valid;
                assign stg_ready[k] = i_ready;
                assign stg_data[k]  = main_q;
            end

            assign in_ready  = reset && stg_ready[0];
            assign out_valid = stg_valid[DEPTH-1];
            assign out_data  = stg_data[DEPTH-1];
            assign push_in   = in_valid && in_ready;
            assign pop_out   = out_valid && out_ready;

            // Occupancy follows push minus pop at the pipe boundaries
            always_comb begin
                count_d = count_q;
                if (push_in && !pop_out)      count_d = count_q + CNTW'(1);
                else if (!push_in && pop_out) count_d = count_q - CNTW'(1);
            end

            // Occupancy register
            always_ff @(posedge clk) begin
                if (!reset) count_q <= '0;
                else        count_q <= count_d;
            end

            assign count = count_q;
            assign empty = (count_q == '0);
            assign full  = (count_q == CNT_MAX);
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Bench for elastic_pipe_register: five instances cover reset, streaming latency,
// back-pressure, randomized handshakes with a scoreboard, partial payload reset and
// the DEPTH==0 pass-through.
module tb_elastic_pipe_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // A: DATAW=8, DEPTH=3
    logic a_rst = 1'b0, a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_empty, a_full;
    logic [7:0] a_id = '0, a_od;
    logic [2:0] a_cnt;
    // B: DATAW=8, DEPTH=2
    logic b_rst = 1'b0, b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_empty, b_full;
    logic [7:0] b_id = '0, b_od;
    logic [2:0] b_cnt;
    // C: DATAW=32, DEPTH=2
    logic c_rst = 1'b0, c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_empty, c_full;
    logic [31:0] c_id = '0, c_od;
    logic [2:0] c_cnt;
    // D: DATAW=16, RESETW=4, DEPTH=1
    logic d_rst = 1'b0, d_iv = 1'b0, d_ir, d_ov, d_or = 1'b0, d_empty, d_full;
    logic [15:0] d_id = '0, d_od;
    logic [1:0] d_cnt;
    // E: DATAW=8, DEPTH=0
    logic e_rst = 1'b0, e_iv = 1'b0, e_ir, e_ov, e_or = 1'b0, e_empty, e_full;
    logic [7:0] e_id = '0, e_od;
    logic [0:0] e_cnt;

    elastic_pipe_register #(.DATAW(8), .DEPTH(3)) u_a (
        .clk(clk), .reset(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt),
        .empty(a_empty), .full(a_full));
    elastic_pipe_register #(.DATAW(8), .DEPTH(2)) u_b (
        .clk(clk), .reset(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt),
        .empty(b_empty), .full(b_full));
    elastic_pipe_register #(.DATAW(32), .DEPTH(2)) u_c (
        .clk(clk), .reset(c_rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .count(c_cnt),
        .empty(c_empty), .full(c_full));
    elastic_pipe_register #(.DATAW(16), .RESETW(4), .DEPTH(1)) u_d (
        .clk(clk), .reset(d_rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .count(d_cnt),
        .empty(d_empty), .full(d_full));
    elastic_pipe_register #(.DATAW(8), .DEPTH(0)) u_e (
        .clk(clk), .reset(e_rst), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
        .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .count(e_cnt),
        .empty(e_empty), .full(e_full));

    // Reset with in_valid held high, then release
    task automatic test_reset();
        a_rst = 1'b0; a_iv = 1'b1; a_id = 8'h55; a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", a_ov); end
            vectors++; if (a_ir !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", a_ir); end
            vectors++; if (a_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
            vectors++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", a_empty, a_full); end
        end
        @(negedge clk); a_rst = 1'b1; a_iv = 1'b0; #1;
        vectors++; if (a_ir !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b want 1", a_ir); end
        vectors++; if (a_ov !== 1'b0) begin miscompares++; $display("FAIL release_out_valid: got %b want 0", a_ov); end
    endtask

    // DEPTH=3 back-to-back stream of 16 beats with out_ready held high
    task automatic test_streaming();
        logic [7:0] exp_q[$];
        logic [7:0] exp_d;
        int sent = 0, got = 0, first_push = -1, first_out = -1;
        a_or = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge clk);
            a_iv = (sent < 16); a_id = 8'(sent + 1);
            #1;
            if (a_ov && a_or) begin
                if (first_out < 0) first_out = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL stream_extra_beat: got %h want none", a_od);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (a_od !== exp_d) begin miscompares++; $display("FAIL stream_data: got %h want %h", a_od, exp_d); end
                end
                got++;
            end else if (first_out >= 0) begin
                vectors++; miscompares++; $display("FAIL stream_bubble: got out_valid=%b want 1 at beat %0d", a_ov, got);
            end
            if (a_iv) begin
                vectors++;
                if (a_ir !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready: got %b want 1", a_ir); end
                if (a_ir) begin
                    exp_q.push_back(a_id);
                    if (first_push < 0) first_push = cyc;
                    sent++;
                end
            end
        end
        vectors++; if (got != 16) begin miscompares++; $display("FAIL stream_beats: got %0d want 16", got); end
        vectors++; if (first_out - first_push != 3) begin miscompares++; $display("FAIL stream_latency: got %0d want 3", first_out - first_push); end
        @(negedge clk); a_iv = 1'b0; #1;
        vectors++; if (a_cnt !== 3'd0 || a_empty !== 1'b1) begin miscompares++; $display("FAIL stream_drained: got count=%0d empty=%b want 0/1", a_cnt, a_empty); end
    endtask

    // DEPTH=2 fill under back-pressure, then drain
    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] exp_d;
        int acc = 0, got = 0, pop_cyc = -1, rdy_cyc = -1;
        b_rst = 1'b0; b_iv = 1'b0; b_or = 1'b0;
        repeat (2) @(negedge clk);
        b_rst = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk); b_iv = 1'b1; b_id = 8'(8'hA0 + acc); #1;
            if (b_iv && b_ir) begin exp_q.push_back(b_id); acc++; end
        end
        @(negedge clk); b_id = 8'(8'hA0 + acc); #1;
        vectors++; if (acc != 4) begin miscompares++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        vectors++; if (b_full !== 1'b1) begin miscompares++; $display("FAIL bp_full: got %b want 1", b_full); end
        vectors++; if (b_ir !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", b_ir); end
        vectors++; if (b_cnt !== 3'd4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", b_cnt); end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            b_or = 1'b1; b_iv = (acc < 6); b_id = 8'(8'hA0 + acc); #1;
            if (b_ir && rdy_cyc < 0) rdy_cyc = cyc;
            if (b_ov && b_or) begin
                if (pop_cyc < 0) pop_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra_beat: got %h want none", b_od);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (b_od !== exp_d) begin miscompares++; $display("FAIL bp_data: got %h want %h", b_od, exp_d); end
                end
                got++;
            end
            if (b_iv && b_ir) begin exp_q.push_back(b_id); acc++; end
        end
        vectors++; if (got != 6) begin miscompares++; $display("FAIL bp_drained: got %0d want 6", got); end
        // ready ripples back one stage per clock after the first pop
        vectors++; if (rdy_cyc - pop_cyc != 2) begin miscompares++; $display("FAIL bp_ready_return: got %0d want 2", rdy_cyc - pop_cyc); end
    endtask

    // Random valid/ready, scoreboard plus occupancy model
    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] exp_d;
        int sent = 0, got = 0, model_cnt = 0, cyc = 0;
        logic holding = 1'b0;
        logic ir_snap;
        c_rst = 1'b0; c_iv = 1'b0; c_or = 1'b0;
        repeat (2) @(negedge clk);
        c_rst = 1'b1;
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk); cyc++;
            if (!holding) begin
                if (sent < 10000 && $urandom_range(0, 1) == 1) begin
                    c_iv = 1'b1; c_id = $urandom; holding = 1'b1;
                end else begin
                    c_iv = 1'b0;
                end
            end
            c_or = ($urandom_range(0, 1) == 1);
            #1;
            ir_snap = c_ir; c_or = ~c_or; #1;
            vectors++; if (c_ir !== ir_snap) begin miscompares++; $display("FAIL rnd_ready_path: got %b want %b", c_ir, ir_snap); end
            c_or = ~c_or; #1;
            vectors++; if (c_cnt !== 3'(model_cnt)) begin miscompares++; $display("FAIL rnd_count: got %0d want %0d", c_cnt, model_cnt); end
            vectors++; if (c_full !== (model_cnt == 4) || c_empty !== (model_cnt == 0)) begin miscompares++; $display("FAIL rnd_flags: got full=%b empty=%b for count %0d", c_full, c_empty, model_cnt); end
            if (c_ov && c_or) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_extra_beat: got %h want none", c_od);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (c_od !== exp_d) begin miscompares++; $display("FAIL rnd_data: got %h want %h", c_od, exp_d); end
                end
                got++; model_cnt--;
            end
            if (c_iv && c_ir) begin
                exp_q.push_back(c_id); sent++; holding = 1'b0; model_cnt++;
            end
        end
        vectors++; if (got != 10000) begin miscompares++; $display("FAIL rnd_beats: got %0d want 10000", got); end
    endtask

    // Partial payload reset: only the top 4 bits are cleared
    task automatic test_partial_reset();
        logic [15:0] exp_q[$];
        logic [15:0] exp_d;
        int loaded = 0;
        d_rst = 1'b0; d_iv = 1'b0; d_or = 1'b0;
        repeat (2) @(negedge clk);
        d_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); d_iv = 1'b1; d_id = 16'hFFFF; #1;
            if (d_iv && d_ir) loaded++;
        end
        @(negedge clk); d_iv = 1'b0; #1;
        vectors++; if (loaded != 2 || d_full !== 1'b1) begin miscompares++; $display("FAIL prst_load: got loaded=%0d full=%b want 2/1", loaded, d_full); end
        vectors++; if (d_ov !== 1'b1 || d_od !== 16'hFFFF) begin miscompares++; $display("FAIL prst_loaded_out: got v=%b d=%h want 1/ffff", d_ov, d_od); end
        @(negedge clk); d_rst = 1'b0; d_iv = 1'b1; d_id = 16'hBEEF; d_or = 1'b1;
        @(negedge clk); #1;
        vectors++; if (d_od[15:12] !== 4'h0) begin miscompares++; $display("FAIL prst_msbs: got %h want 0", d_od[15:12]); end
        vectors++; if (d_ov !== 1'b0 || d_cnt !== 2'd0) begin miscompares++; $display("FAIL prst_state: got v=%b count=%0d want 0/0", d_ov, d_cnt); end
        vectors++; if (d_ir !== 1'b0) begin miscompares++; $display("FAIL prst_ready_forced: got %b want 0", d_ir); end
        @(negedge clk); d_rst = 1'b1; d_iv = 1'b0; #1;
        vectors++; if (d_ir !== 1'b1 || d_cnt !== 2'd0) begin miscompares++; $display("FAIL prst_release: got ready=%b count=%0d want 1/0", d_ir, d_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vectors++; if (d_ov !== 1'b0) begin miscompares++; $display("FAIL prst_stale_out: got %b want 0", d_ov); end
        end
        @(negedge clk); d_iv = 1'b1; d_id = 16'h1234; #1;
        if (d_iv && d_ir) exp_q.push_back(d_id);
        @(negedge clk); d_iv = 1'b0; #1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("FAIL prst_push: got ready=0 want 1");
        end else begin
            exp_d = exp_q.pop_front();
            if (d_ov !== 1'b1 || d_od !== exp_d) begin miscompares++; $display("FAIL prst_after: got v=%b d=%h want 1/%h", d_ov, d_od, exp_d); end
        end
    endtask

    // DEPTH=0 is a wire: outputs follow inputs in the same cycle
    task automatic test_depth0();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e_rst = i[2]; e_iv = i[0]; e_or = i[1]; e_id = 8'($urandom);
            #1;
            vectors++; if (e_ov !== e_iv) begin miscompares++; $display("FAIL d0_out_valid: got %b want %b", e_ov, e_iv); end
            vectors++; if (e_ir !== e_or) begin miscompares++; $display("FAIL d0_in_ready: got %b want %b", e_ir, e_or); end
            vectors++; if (e_od !== e_id) begin miscompares++; $display("FAIL d0_data: got %h want %h", e_od, e_id); end
            vectors++; if (e_cnt !== 1'b0 || e_empty !== 1'b1 || e_full !== 1'b1) begin miscompares++; $display("FAIL d0_flags: got count=%0d empty=%b full=%b want 0/1/1", e_cnt, e_empty, e_full); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_partial_reset();
        test_depth0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time limit, want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
